seq_ctrl: RTL

- Multi-cycle control sequencer for the 16-bit datapath.
- Steps each instruction through fetch, decode, execute, memory and write-back.
- Per state, drives the ALU operand-select code (alu_in_sel), the ALU function, register/PC/IR load strobes and a memory request/ready handshake.
- Sits between the instruction register, register file and memory interface; it is the only block that drives alu_in_sel.

---
 rtl/seq_pkg.sv | 42 ++++
 rtl/seq_decode.sv | 96 +++++++++
 rtl/seq_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared encodings for the multi-cycle control sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpAdd  = 4'h1;
  localparam logic [3:0] OpMov  = 4'h2;
  localparam logic [3:0] OpAddi = 4'h3;
  localparam logic [3:0] OpLd   = 4'h4;
  localparam logic [3:0] OpSt   = 4'h5;
  localparam logic [3:0] OpJr   = 4'h6;
  localparam logic [3:0] OpJz   = 4'h7;
  localparam logic [3:0] OpSub  = 4'h8;
  localparam logic [3:0] OpHalt = 4'hF;

  localparam logic [2:0] SelSrDr   = 3'b000;
  localparam logic [2:0] SelSr0    = 3'b001;
  localparam logic [2:0] Sel0Dr    = 3'b010;
  localparam logic [2:0] SelOffPc  = 3'b011;
  localparam logic [2:0] Sel0Pc    = 3'b100;
  localparam logic [2:0] Sel0Data  = 3'b101;
  localparam logic [2:0] SelImmDr  = 3'b110;
  localparam logic [2:0] SelDataDr = 3'b111;

  localparam logic [1:0] AluAdd    = 2'b00;
  localparam logic [1:0] AluPassDr = 2'b01;
  localparam logic [1:0] AluSub    = 2'b10;

  function automatic logic is_legal_op(logic [3:0] op);
    return (op <= OpSub) || (op == OpHalt);
  endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational output decode: state + latched opcode (+ alu_zero, mem_ready) to strobes.
module seq_decode
  import seq_pkg::*;
(
  input  logic [2:0] state,
  input  logic [3:0] op,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic [2:0] alu_in_sel,
  output logic [1:0] alu_op,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       addr_load,
  output logic       reg_we,
  output logic       mem_req,
  output logic       mem_we
);

  state_e st;
  assign st = state_e'(state);

  // Per-state strobe decode; everything defaults low / code 0.
  always_comb begin
    alu_in_sel = SelSrDr;
    alu_op     = AluAdd;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    addr_load  = 1'b0;
    reg_we     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    case (st)
      StFetch: begin
        mem_req    = 1'b1;
        alu_in_sel = Sel0Pc;
        alu_op     = AluPassDr;
        ir_load    = mem_ready;
        pc_inc     = mem_ready;
      end
      StExec: begin
        case (op)
          OpAdd: begin
            alu_in_sel = SelSrDr;
            reg_we     = 1'b1;
          end
          OpMov: begin
            alu_in_sel = SelSr0;
            reg_we     = 1'b1;
          end
          OpAddi: begin
            alu_in_sel = SelImmDr;
            reg_we     = 1'b1;
          end
          OpLd: begin
            alu_in_sel = SelSr0;
            addr_load  = 1'b1;
          end
          OpSt: begin
            alu_in_sel = Sel0Dr;
            addr_load  = 1'b1;
          end
          OpJr: begin
            alu_in_sel = SelOffPc;
            pc_load    = 1'b1;
          end
          OpJz: begin
            alu_in_sel = SelOffPc;
            pc_load    = alu_zero;
          end
          OpSub: begin
            alu_in_sel = SelSrDr;
            alu_op     = AluSub;
            reg_we     = 1'b1;
          end
          default: ;
        endcase
      end
      StMem: begin
        mem_req = 1'b1;
        if (op == OpSt) begin
          mem_we     = 1'b1;
          // sr carries the store data through the ALU
          alu_in_sel = SelSr0;
        end
      end
      StWb: begin
        alu_in_sel = Sel0Data;
        reg_we     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle control sequencer: FSM, memory wait timer and retired-instruction counter.
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [15:0]      ir,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic [2:0]       alu_in_sel,
  output logic [1:0]       alu_op,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             addr_load,
  output logic             reg_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic             halted,
  output logic             bus_err,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  // The last permitted wait cycle: no ready here means bus error.
  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
  logic             illegal_q, illegal_d;

  logic unused_ir;
  assign unused_ir = ^ir[11:0];

  // Next-state, wait timer, retirement count and sticky flags.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wait_d    = wait_q;
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
    illegal_d = illegal_q;
    case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StFetch;
          wait_d  = 8'd0;
        end
      end
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (wait_q == WaitLast) begin
          bus_err_d = 1'b1;
          state_d   = StHalt;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StDecode: begin
        op_d    = ir[15:12];
        state_d = StExec;
      end
      StExec: begin
        if (op_q == OpLd || op_q == OpSt) begin
          state_d = StMem;
          wait_d  = 8'd0;
        end else if (op_q == OpHalt) begin
          state_d = StHalt;
        end else begin
          if (!is_legal_op(op_q)) illegal_d = 1'b1;
          state_d = StFetch;
          wait_d  = 8'd0;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      StMem: begin
        if (mem_ready) begin
          if (op_q == OpSt) begin
            state_d = StFetch;
            wait_d  = 8'd0;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            state_d = StWb;
          end
        end else if (wait_q == WaitLast) begin
          bus_err_d = 1'b1;
          state_d   = StHalt;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StWb: begin
        state_d = StFetch;
        wait_d  = 8'd0;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      StHalt: ;
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= 4'h0;
      wait_q    <= 8'd0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
      illegal_q <= illegal_d;
    end
  end

  seq_decode u_decode (
    .state      (state_q),
    .op         (op_q),
    .alu_zero   (alu_zero),
    .mem_ready  (mem_ready),
    .alu_in_sel (alu_in_sel),
    .alu_op     (alu_op),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .addr_load  (addr_load),
    .reg_we     (reg_we),
    .mem_req    (mem_req),
    .mem_we     (mem_we)
  );

  assign halted    = (state_q == StHalt);
  assign bus_err   = bus_err_q;
  assign illegal   = illegal_q;
  assign instr_cnt = cnt_q;

endmodule
